router_out_reader: RTL and testbench
====================================

# router_out_reader

Destination-side packet reader for one output port of the 1x3 router. It drains packets from the port FIFO using the `vld_out_x`/`read_enb_x` pair and strips the header and parity bytes. Payload bytes are delivered on a valid/ready byte stream, and parity is checked per packet. Reads are issued early enough to keep the router's 30-cycle soft-reset watchdog from firing while the sink accepts data. If the watchdog does fire (`soft_reset_x`), the in-flight packet is aborted cleanly. One instance sits on each of ports 0, 1 and 2.

## Interface
Parameters:
- `TIMEOUT`, 30: router watchdog length in cycles; used only for the `stall_warn` output.
- `WARN_MARGIN`, 4: `stall_warn` asserts this many cycles before the watchdog expires.

Ports:
- `clock`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `vld_out`  in  1  port FIFO non-empty.
- `data_out`  in  8  FIFO read data; valid exactly 1 cycle after `read_enb`.
- `soft_reset`  in  1  router watchdog fired; FIFO contents flushed.
- `read_enb`  out  1  FIFO read strobe (combinational from state, counters and `vld_out`).
- `m_data`  out  8  payload byte to sink.
- `m_valid`  out  1  `m_data` valid.
- `m_last`  out  1  qualifies the final payload byte of a packet.
- `m_ready`  in  1  sink accepts the byte when `m_valid & m_ready`.
- `pkt_len`  out  6  payload length of the current or last packet (header bits [7:2]).
- `pkt_done`  out  1  1-cycle pulse when the parity byte is checked.
- `pkt_err`  out  1  1-cycle pulse, coincident with `pkt_done`, on parity mismatch.
- `pkt_abort`  out  1  1-cycle pulse when a packet is aborted by `soft_reset`.
- `busy`  out  1  state not IDLE, or output buffer not empty.
- `stall_warn`  out  1  `vld_out` high with no read for ≥ `TIMEOUT-WARN_MARGIN` cycles.

## Operation
- Packet format: header (`[7:2]` = L, 0..63; `[1:0]` = address, ignored), then L payload bytes, then a parity byte. Parity byte must equal the XOR of the header and all payload bytes.
- Output buffer: 2-entry FIFO feeding `m_data`/`m_valid`/`m_last`.
- Read credit: `read_enb` allowed only if buffer occupancy + in-flight reads < 2. At most 1 read is in flight.
- States:
  - IDLE: `read_enb = vld_out`. A read moves the FSM to HEAD.
  - HEAD: header arrives on `data_out`. Capture L into `pkt_len`, seed the parity accumulator, load `remaining = L+1` (9-bit), go to BODY.
  - BODY: `read_enb = vld_out & credit & (remaining_to_issue != 0)`.
    - Each arriving byte is XORed into the accumulator.
    - Payload bytes are pushed into the buffer; `m_last` is set on byte L.
    - The parity byte is not pushed. On parity arrival, go to CHECK.
  - CHECK: pulse `pkt_done`; pulse `pkt_err` if the accumulator is nonzero. Return to IDLE.
- Speculative read: the first BODY read may issue in the same cycle the header arrives, because at least the parity byte always follows.
- L = 0: header, then parity; no `m_valid` for the packet.
- `vld_out` low mid-packet: stall, no reads, state held.
- `soft_reset` (any state other than IDLE):
  - Abort: flush the buffer and drop the in-flight read data.
  - Pulse `pkt_abort`; no `pkt_done`.
  - Go to IDLE next cycle.
  - `soft_reset` in IDLE: ignored except that the stall counter clears.
- `stall_warn` counter: 5-bit, saturating.
  - Clears on `read_enb`, `!vld_out` or `soft_reset`.
  - Otherwise increments.

## Timing
- Reset values: state IDLE, buffer empty, `m_valid`=0, `m_last`=0, `read_enb`=0, all pulses 0, `pkt_len`=0, `busy`=0, `stall_warn`=0, counters 0.
- Header read at cycle N gives header capture at N+1. Back-to-back reads are possible, so the first payload byte reaches `m_valid` at N+3 at the earliest.
- Full-rate throughput (`m_ready`=1): 1 byte/cycle. A packet with payload L occupies L+2 read cycles, and `pkt_done` pulses 2 cycles after the parity read.
- Next packet's header read may issue in the cycle after CHECK. Buffered bytes of the previous packet may still be draining; ordering is preserved.
- `m_valid`/`m_data`/`m_last` are held stable until accepted.
- `soft_reset` has priority over every other event in the same cycle.

## Test plan
- L=3, payload A1 B2 C3, correct parity, `m_ready`=1:
  - 5 reads, 3 beats with `m_last` on C3.
  - `pkt_done`=1, `pkt_err`=0, `pkt_len`=3.
- Same packet with parity byte XOR 0x01 → payload delivered unchanged, `pkt_done` and `pkt_err` pulse together.
- L=0 packet (header 0x02, parity 0x02) → no `m_valid`, `pkt_done`=1, `pkt_err`=0.
- L=8, `m_ready` low after beat 2 for 40 cycles:
  - `read_enb` stops at buffer occupancy 2, `stall_warn` at cycle 26.
  - Inject `soft_reset` → `pkt_abort` pulse, `m_valid`=0 next cycle, state IDLE.
- Two back-to-back packets (L=63, L=1), `m_ready` toggling 50% → 64 beats total, `m_last` on beats 63 and 64, two `pkt_done` pulses, no byte loss or reorder.
- Assert `reset` mid-BODY → all outputs at reset values next cycle; the next packet is received correctly.

Source files
------------

// File: rtl/router_out_reader.sv
// router_out_reader: drains one router output port FIFO, strips header and
// parity, streams the payload over valid/ready and checks per-packet parity.
// A watchdog soft reset aborts the packet in flight and flushes buffered bytes.
module router_out_reader #(
  parameter int TIMEOUT     = 30,
  parameter int WARN_MARGIN = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       vld_out,
  input  logic [7:0] data_out,
  input  logic       soft_reset,
  output logic       read_enb,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_last,
  input  logic       m_ready,
  output logic [5:0] pkt_len,
  output logic       pkt_done,
  output logic       pkt_err,
  output logic       pkt_abort,
  output logic       busy,
  output logic       stall_warn
);

  localparam logic [31:0] WARN_AT   = 32'(TIMEOUT - WARN_MARGIN);
  localparam logic [4:0]  STALL_MAX = 5'd31;

  typedef enum logic [1:0] {IDLE, HEAD, BODY, CHECK} state_t;

  state_t     state_reg;
  logic       inflight_reg;   // a read was issued last cycle; its byte is on data_out now
  logic [8:0] issue_reg;      // post-header reads still to issue
  logic [8:0] recv_reg;       // post-header bytes still to arrive (payload + parity)
  logic [7:0] acc_reg;
  logic [5:0] len_reg;
  logic       done_reg;
  logic       err_reg;
  logic       abort_reg;
  logic [4:0] stall_reg;

  // Output buffer: two entries addressed by single-bit pointers
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic [1:0][7:0] entry_data;
  logic [1:0]      entry_last;

  logic abort;
  logic body_push_arr;
  logic push;
  logic pop;
  logic credit;

  // Abort only matters while a packet is being worked on
  assign abort = soft_reset && (state_reg != IDLE);

  // Byte arriving this cycle that belongs in the output buffer (payload, not parity)
  assign body_push_arr = (state_reg == BODY) && inflight_reg && (recv_reg > 9'd1);
  assign push          = body_push_arr && !abort;
  assign pop           = m_valid && m_ready;

  // A new read may only issue if its byte is guaranteed a free entry one cycle later
  assign credit = ({1'b0, count_reg} + {2'b0, body_push_arr}) < (3'd2 + {2'b0, pop});

  // Read strobe: header reads in IDLE, credit-limited payload/parity reads afterwards
  always_comb begin
    read_enb = 1'b0;
    if (!reset) begin
      case (state_reg)
        IDLE:    read_enb = vld_out;
        HEAD:    read_enb = vld_out && credit && !soft_reset;
        BODY:    read_enb = vld_out && credit && !soft_reset && (issue_reg != 9'd0);
        default: read_enb = 1'b0;
      endcase
    end
  end

  // Packet FSM: header capture, byte accounting, parity check and abort handling
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      inflight_reg <= 1'b0;
      issue_reg    <= 9'd0;
      recv_reg     <= 9'd0;
      acc_reg      <= 8'd0;
      len_reg      <= 6'd0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      abort_reg    <= 1'b0;
    end else begin
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      abort_reg <= 1'b0;
      if (abort) begin
        state_reg    <= IDLE;
        inflight_reg <= 1'b0;
        abort_reg    <= 1'b0 | 1'b1;
      end else begin
        inflight_reg <= read_enb;
        case (state_reg)
          IDLE: begin
            if (read_enb) state_reg <= HEAD;
          end
          HEAD: begin
            // The parity byte always follows, so a read here is already accounted for
            len_reg   <= data_out[7:2];
            acc_reg   <= data_out;
            recv_reg  <= {3'd0, data_out[7:2]} + 9'd1;
            issue_reg <= {3'd0, data_out[7:2]} + 9'd1 - {8'd0, read_enb};
            state_reg <= BODY;
          end
          BODY: begin
            if (read_enb) issue_reg <= issue_reg - 9'd1;
            if (inflight_reg) begin
              acc_reg  <= acc_reg ^ data_out;
              recv_reg <= recv_reg - 9'd1;
              if (recv_reg == 9'd1) begin
                state_reg <= CHECK;
                done_reg  <= 1'b1;
                err_reg   <= (acc_reg ^ data_out) != 8'd0;
              end
            end
          end
          CHECK: begin
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  // Output buffer pointers and occupancy; an abort discards everything buffered
  always_ff @(posedge clock) begin
    if (reset || abort) begin
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
      count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [7:0] data_reg;
      logic       last_reg;

      // Buffer entry storage: written when the write pointer selects this slot
      always_ff @(posedge clock) begin
        if (reset) begin
          data_reg <= 8'd0;
          last_reg <= 1'b0;
        end else if (push && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= data_out;
          last_reg <= (recv_reg == 9'd2);
        end
      end

      assign entry_data[gi] = data_reg;
      assign entry_last[gi] = last_reg;
    end
  endgenerate

  // Watchdog shadow: counts cycles the port has data but no read is issued
  always_ff @(posedge clock) begin
    if (reset || read_enb || !vld_out || soft_reset) begin
      stall_reg <= 5'd0;
    end else if (stall_reg != STALL_MAX) begin
      stall_reg <= stall_reg + 5'd1;
    end
  end

  assign m_valid    = (count_reg != 2'd0);
  assign m_data     = entry_data[rd_ptr_reg];
  assign m_last     = m_valid && entry_last[rd_ptr_reg];
  assign pkt_len    = len_reg;
  assign pkt_done   = done_reg;
  assign pkt_err    = err_reg;
  assign pkt_abort  = abort_reg;
  assign busy       = (state_reg != IDLE) || (count_reg != 2'd0);
  assign stall_warn = ({27'd0, stall_reg} >= WARN_AT);

endmodule

// File: tb/tb_router_out_reader.sv
// tb_router_out_reader: drives router_out_reader from a modelled port FIFO
// (one-cycle read latency) and compares the delivered byte stream, packet
// pulses and timing against expectations built from the packet contents.
module tb_router_out_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       vld_out;
  logic [7:0] data_out;
  logic       soft_reset;
  logic       read_enb;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic [5:0] pkt_len;
  logic       pkt_done;
  logic       pkt_err;
  logic       pkt_abort;
  logic       busy;
  logic       stall_warn;

  always #5 clock = ~clock;

  router_out_reader #(.TIMEOUT(30), .WARN_MARGIN(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .vld_out    (vld_out),
    .data_out   (data_out),
    .soft_reset (soft_reset),
    .read_enb   (read_enb),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .pkt_len    (pkt_len),
    .pkt_done   (pkt_done),
    .pkt_err    (pkt_err),
    .pkt_abort  (pkt_abort),
    .busy       (busy),
    .stall_warn (stall_warn)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] src_q[$];   // router port FIFO contents
  logic [8:0] got_q[$];   // {last, data} accepted from the DUT
  logic [8:0] exp_q[$];   // {last, data} expected from the packet definitions

  int n_reads, n_done, n_err, n_err_alone, n_abort, hold_viol;
  int cyc = 0;
  int first_rd, last_rd, first_vld, done_cyc;
  int ready_pct = 100;
  int vld_pct   = 100;

  logic        s_read, s_vld, s_valid, s_warn, s_busy, s_abort;
  logic [13:0] s_outs;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0, p_flush = 1'b0;
  logic [7:0]  p_data = 8'd0;

  task automatic clear_stats();
    n_reads = 0; n_done = 0; n_err = 0; n_err_alone = 0; n_abort = 0; hold_viol = 0;
    first_rd = -1; last_rd = -1; first_vld = -1; done_cyc = -1;
    got_q.delete();
    exp_q.delete();
  endtask

  // Build one packet into the port FIFO and its payload into the expected stream
  task automatic add_packet(input logic [1:0] addr, input logic [7:0] pay[$], input logic [7:0] err_mask);
    logic [7:0] hdr;
    logic [7:0] par;
    hdr = {6'(pay.size()), addr};
    par = hdr;
    src_q.push_back(hdr);
    for (int i = 0; i < pay.size(); i++) begin
      src_q.push_back(pay[i]);
      par = par ^ pay[i];
      exp_q.push_back({(i == pay.size() - 1) ? 1'b1 : 1'b0, pay[i]});
    end
    src_q.push_back(par ^ err_mask);
  endtask

  // One clock: sample outputs mid-cycle, then update FIFO/sink inputs after the edge
  task automatic cycle();
    logic rd;
    @(negedge clock);
    rd      = read_enb;
    s_read  = read_enb;
    s_vld   = vld_out;
    s_valid = m_valid;
    s_warn  = stall_warn;
    s_busy  = busy;
    s_abort = pkt_abort;
    s_outs  = {read_enb, m_valid, m_last, pkt_done, pkt_err, pkt_abort, busy, stall_warn, pkt_len};
    if (rd) begin
      n_reads++;
      if (first_rd < 0) first_rd = cyc;
      last_rd = cyc;
    end
    if (m_valid && first_vld < 0) first_vld = cyc;
    if (m_valid && m_ready) got_q.push_back({m_last, m_data});
    if (pkt_done) begin
      n_done++;
      done_cyc = cyc;
      $display("pkt_done len=%0d err=%0d beats=%0d t=%0t", pkt_len, pkt_err, got_q.size(), $time);
    end
    if (pkt_err) n_err++;
    if (pkt_err && !pkt_done) n_err_alone++;
    if (pkt_abort) n_abort++;
    if (p_valid && !p_ready && !p_flush && !reset)
      if (!m_valid || m_data !== p_data || m_last !== p_last) hold_viol++;
    p_valid = m_valid; p_ready = m_ready; p_data = m_data; p_last = m_last;
    p_flush = reset || soft_reset;
    @(posedge clock);
    #1;
    cyc++;
    if (rd) begin
      if (src_q.size() > 0) data_out = src_q.pop_front();
      else data_out = 8'($urandom);
    end
    vld_out = (src_q.size() != 0) && ($urandom_range(99) < ready_or_vld(1));
    m_ready = ($urandom_range(99) < ready_or_vld(0));
  endtask

  function automatic int ready_or_vld(input bit sel_vld);
    return sel_vld ? vld_pct : ready_pct;
  endfunction

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (src_q.size() == 0 && !s_busy && !vld_out) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic bit stream_matches();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (got_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1; soft_reset = 1'b0; vld_out = 1'b1; data_out = 8'h00; m_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    obs = {read_enb, m_valid, m_last, pkt_done, pkt_err, pkt_abort, busy, stall_warn, pkt_len};
    checks++;
    if (obs !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required %b", obs, 14'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0; vld_out = 1'b0;
    clear_stats();
    cycle();
    checks++;
    if (s_outs !== 14'd0) begin
      errors++;
      $display("FAIL reset_idle: got %b, required %b", s_outs, 14'd0);
    end
  endtask

  task automatic test_basic();
    logic [7:0] pay[$];
    bit ok;
    clear_stats(); ready_pct = 100; vld_pct = 100; m_ready = 1'b1;
    pay = {8'hA1, 8'hB2, 8'hC3};
    add_packet(2'd1, pay, 8'h00);
    drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_drain: timed out, required idle"); end
    checks++; if (n_reads != 5) begin errors++; $display("FAIL basic_reads: got %0d, required 5", n_reads); end
    checks++; if (first_vld - first_rd != 3) begin errors++; $display("FAIL basic_latency: got %0d, required 3", first_vld - first_rd); end
    checks++; if (last_rd - first_rd != 4) begin errors++; $display("FAIL basic_read_span: got %0d, required 4", last_rd - first_rd); end
    checks++; if (done_cyc - last_rd != 2) begin errors++; $display("FAIL basic_done_latency: got %0d, required 2", done_cyc - last_rd); end
    checks++; if (!stream_matches()) begin errors++; $display("FAIL basic_stream: got %0d beats, required %0d matching beats", got_q.size(), exp_q.size()); end
    checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL basic_status: got done=%0d err=%0d, required done=1 err=0", n_done, n_err); end
    checks++; if (pkt_len !== 6'd3) begin errors++; $display("FAIL basic_len: got %0d, required 3", pkt_len); end
  endtask

  task automatic test_parity_err();
    logic [7:0] pay[$];
    bit ok;
    clear_stats(); ready_pct = 100; vld_pct = 100;
    pay = {8'hA1, 8'hB2, 8'hC3};
    add_packet(2'd1, pay, 8'h01);
    drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL perr_drain: timed out, required idle"); end
    checks++; if (!stream_matches()) begin errors++; $display("FAIL perr_stream: got %0d beats, required %0d matching beats", got_q.size(), exp_q.size()); end
    checks++; if (n_done != 1 || n_err != 1 || n_err_alone != 0) begin errors++; $display("FAIL perr_status: got done=%0d err=%0d lone_err=%0d, required 1 1 0", n_done, n_err, n_err_alone); end
  endtask

  task automatic test_zero_len();
    logic [7:0] pay[$];
    bit ok;
    clear_stats(); ready_pct = 100; vld_pct = 100;
    pay.delete();
    add_packet(2'd2, pay, 8'h00);
    drain(200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL zero_drain: timed out, required idle"); end
    checks++; if (first_vld != -1) begin errors++; $display("FAIL zero_no_valid: got m_valid at cycle %0d, required none", first_vld); end
    checks++; if (n_done != 1 || n_err != 0) begin errors++; $display("FAIL zero_status: got done=%0d err=%0d, required done=1 err=0", n_done, n_err); end
    checks++; if (pkt_len !== 6'd0) begin errors++; $display("FAIL zero_len: got %0d, required 0", pkt_len); end
    checks++; if (n_reads != 2) begin errors++; $display("FAIL zero_reads: got %0d, required 2", n_reads); end
  endtask

  task automatic test_backpressure_abort();
    logic [7:0] pay[$];
    int run, warn_run;
    clear_stats(); ready_pct = 100; vld_pct = 100;
    for (int i = 0; i < 8; i++) pay.push_back(8'($urandom));
    add_packet(2'd0, pay, 8'h00);
    run = 0; warn_run = -1;
    for (int i = 0; i < 100 && got_q.size() < 2; i++) begin
      cycle();
      if (s_vld && !s_read) run++; else run = 0;
    end
    ready_pct = 0; m_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (s_warn && warn_run < 0) warn_run = run;
      if (s_vld && !s_read) run++; else run = 0;
    end
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp_beats: got %0d, required 2", got_q.size()); end
    checks++; if (n_reads != 5) begin errors++; $display("FAIL bp_reads: got %0d, required 5", n_reads); end
    checks++; if (warn_run != 26) begin errors++; $display("FAIL bp_stall_warn: first warn after %0d idle cycles, required 26", warn_run); end
    soft_reset = 1'b1;
    src_q.delete();
    cycle();
    soft_reset = 1'b0;
    cycle();
    checks++; if (s_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse: got %b, required 1", s_abort); end
    checks++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin errors++; $display("FAIL abort_flush: got valid=%b busy=%b, required 0 0", s_valid, s_busy); end
    checks++; if (s_warn !== 1'b0) begin errors++; $display("FAIL abort_warn_clear: got %b, required 0", s_warn); end
    repeat (3) cycle();
    checks++; if (n_abort != 1 || n_done != 0) begin errors++; $display("FAIL abort_counts: got abort=%0d done=%0d, required 1 0", n_abort, n_done); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pay[$];
    bit ok;
    int lasts;
    clear_stats(); ready_pct = 50; vld_pct = 100;
    for (int i = 0; i < 63; i++) pay.push_back(8'($urandom));
    add_packet(2'd1, pay, 8'h00);
    pay.delete();
    pay.push_back(8'($urandom));
    add_packet(2'd2, pay, 8'h00);
    drain(2000, ok);
    lasts = 0;
    foreach (got_q[i]) if (got_q[i][8]) lasts++;
    checks++; if (!ok) begin errors++; $display("FAIL b2b_drain: timed out, required idle"); end
    checks++; if (!stream_matches()) begin errors++; $display("FAIL b2b_stream: got %0d beats, required %0d matching beats", got_q.size(), exp_q.size()); end
    checks++; if (got_q.size() != 64 || lasts != 2 || !got_q[62][8] || !got_q[63][8]) begin errors++; $display("FAIL b2b_last: got %0d beats %0d lasts, required 64 beats, last on 63 and 64", got_q.size(), lasts); end
    checks++; if (n_done != 2 || n_err != 0) begin errors++; $display("FAIL b2b_status: got done=%0d err=%0d, required 2 0", n_done, n_err); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL b2b_hold: got %0d unstable beats, required 0", hold_viol); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] pay[$];
    bit ok;
    clear_stats(); ready_pct = 100; vld_pct = 100;
    for (int i = 0; i < 10; i++) pay.push_back(8'($urandom));
    add_packet(2'd0, pay, 8'h00);
    for (int i = 0; i < 100 && got_q.size() < 3; i++) cycle();
    reset = 1'b1;
    src_q.delete();
    cycle();
    cycle();
    checks++; if (s_outs !== 14'd0) begin errors++; $display("FAIL rst_mid_outputs: got %b, required %b", s_outs, 14'd0); end
    reset = 1'b0;
    clear_stats();
    pay.delete();
    for (int i = 0; i < 5; i++) pay.push_back(8'($urandom));
    add_packet(2'd3, pay, 8'h00);
    drain(300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_drain: timed out, required idle"); end
    checks++; if (!stream_matches()) begin errors++; $display("FAIL rst_mid_stream: got %0d beats, required %0d matching beats", got_q.size(), exp_q.size()); end
    checks++; if (n_done != 1 || n_err != 0 || pkt_len !== 6'd5) begin errors++; $display("FAIL rst_mid_status: got done=%0d err=%0d len=%0d, required 1 0 5", n_done, n_err, pkt_len); end
  endtask

  task automatic test_random();
    logic [7:0] pay[$];
    bit ok;
    int exp_err;
    clear_stats(); ready_pct = 60; vld_pct = 80; exp_err = 0;
    for (int p = 0; p < 6; p++) begin
      pay.delete();
      for (int i = 0; i < $urandom_range(20); i++) pay.push_back(8'($urandom));
      if ($urandom_range(2) == 0) begin
        exp_err++;
        add_packet(2'($urandom_range(2)), pay, 8'($urandom_range(255, 1)));
      end else begin
        add_packet(2'($urandom_range(2)), pay, 8'h00);
      end
    end
    drain(4000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain: timed out, required idle"); end
    checks++; if (!stream_matches()) begin errors++; $display("FAIL rand_stream: got %0d beats, required %0d matching beats", got_q.size(), exp_q.size()); end
    checks++; if (n_done != 6 || n_err != exp_err || n_err_alone != 0) begin errors++; $display("FAIL rand_status: got done=%0d err=%0d, required 6 %0d", n_done, n_err, exp_err); end
    checks++; if (hold_viol != 0) begin errors++; $display("FAIL rand_hold: got %0d unstable beats, required 0", hold_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_zero_len();
    test_backpressure_abort();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

endmodule
